// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch FSM state type and fetch-stage constants
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Canonical addi x0,x0,0; the IF/ID flush path reuses it
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC register, single-outstanding imem FSM and IF/ID-facing output register
// Define IF_MISALIGN_CHECK_EN to trap misaligned redirect targets instead of clearing their low bits.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if,
  output logic [31:0] instr_if,
  output logic        fetch_valid,
  output logic        fetch_busy
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_pc4_q, out_pc4_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_plus_4;
  logic [31:0]  redirect_target;
  logic         req_blocked;
  logic         consume;

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  // Sticky until a redirect lands on an aligned target
  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect) begin
      misaligned_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign req_blocked      = misaligned_q;
  assign redirect_target  = redirect_pc;
  assign fetch_misaligned = misaligned_q;
`else
  assign req_blocked      = 1'b0;
  assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign pc_plus_4 = pc_q + 32'd4;
  assign consume   = valid_q && !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_pc4_d   = out_pc4_q;
    out_instr_d = out_instr_q;
    valid_d     = valid_q;
    imem_req    = 1'b0;

    if (consume) begin
      out_pc_d    = 32'd0;
      out_pc4_d   = 32'd0;
      out_instr_d = NOP_INSTR;
      valid_d     = 1'b0;
    end

    case (state_q)
      REQ: begin
        // Only request when the output register has room by the time data returns
        imem_req = (!valid_q || !stall) && !req_blocked;
        if (imem_req && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          out_pc_d    = pc_q;
          out_pc4_d   = pc_plus_4;
          out_instr_d = imem_rdata;
          valid_d     = 1'b1;
          pc_d        = pc_plus_4;
          state_d     = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    // Redirect overrides everything above; any in-flight response becomes stale
    if (redirect) begin
      pc_d        = redirect_target;
      out_pc_d    = 32'd0;
      out_pc4_d   = 32'd0;
      out_instr_d = NOP_INSTR;
      valid_d     = 1'b0;
      case (state_q)
        REQ:       state_d = (imem_req && imem_gnt) ? DROP : REQ;
        WAIT, DROP: state_d = imem_rvalid ? REQ : DROP;
        default:   state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      out_pc_q    <= 32'd0;
      out_pc4_q   <= 32'd0;
      out_instr_q <= NOP_INSTR;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_pc4_q   <= out_pc4_d;
      out_instr_q <= out_instr_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc_if        = out_pc_q;
  assign pc_plus_4_if = out_pc4_q;
  assign instr_if     = out_instr_q;
  assign fetch_valid  = valid_q;
  assign fetch_busy   = !valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_if, pc_plus_4_if, instr_if;
  logic        fetch_valid, fetch_busy;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc_if        (pc_if),
    .pc_plus_4_if (pc_plus_4_if),
    .instr_if     (instr_if),
    .fetch_valid  (fetch_valid),
`ifdef IF_MISALIGN_CHECK_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .fetch_busy   (fetch_busy)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int          cyc = 0;
  int          last_redir = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          due;
  int          gnt_pct, stall_pct, lat_max;
  bit          directed = 1'b0;
  int          next_dir_cyc = 2;
  int          dir_consumed = 0;
  int          consumed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Instruction stream IF/ID must see after a (re)start at tgt: sequential words, wrapping mod 2^32
  task automatic load_stream(input logic [31:0] tgt);
    logic [31:0] a;
    exp_t e;
    exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) return;
`endif
    a = {tgt[31:2], 2'b00};
    for (int i = 0; i < 128; i++) begin
      e.pc    = a;
      e.pc4   = a + 32'd4;
      e.instr = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    int unsigned k;
    t = $urandom;
    k = $urandom_range(3);
    if (k == 0) t = {22'd0, t[9:0]};
    else if (k == 1) t = {24'hFF_FFFF, t[7:0]};
`ifdef IF_MISALIGN_CHECK_EN
    if ($urandom_range(4) != 0) t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  task automatic capture();
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      chk(!pend, "single_outstanding", {31'd0, pend}, 32'd0);
      pend      = 1'b1;
      pend_addr = imem_addr;
      due       = cyc + int'($urandom_range(lat_max, 1));
    end
  endtask

  task automatic step(input bit do_redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = pend && (cyc == due);
    imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom;
    if (imem_rvalid) pend = 1'b0;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    stall       = ($urandom_range(99) < stall_pct);
    redirect    = do_redir;
    redirect_pc = do_redir ? tgt : $urandom;
    if (do_redir) begin
      last_redir = cyc;
      load_stream(tgt);
    end
    capture();
  endtask

  // Monitor: every consume pops the scoreboard; idle/hold rules checked each cycle
  initial begin
    bit          hold_prev = 1'b0;
    logic [31:0] p_pc, p_pc4, p_instr;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk(fetch_busy == !fetch_valid, "busy_vs_valid", {31'd0, fetch_busy}, {31'd0, !fetch_valid});
        if (!fetch_valid) begin
          chk(pc_if == 32'd0, "idle_pc", pc_if, 32'd0);
          chk(pc_plus_4_if == 32'd0, "idle_pc4", pc_plus_4_if, 32'd0);
          chk(instr_if == NOP, "idle_instr", instr_if, NOP);
        end
        if (hold_prev) begin
          chk(pc_if == p_pc, "hold_pc", pc_if, p_pc);
          chk(pc_plus_4_if == p_pc4, "hold_pc4", pc_plus_4_if, p_pc4);
          chk(instr_if == p_instr, "hold_instr", instr_if, p_instr);
        end
        if (fetch_valid && stall) begin
          chk(!imem_req, "stall_no_req", {31'd0, imem_req}, 32'd0);
        end
`ifdef IF_MISALIGN_CHECK_EN
        if (fetch_misaligned) begin
          chk(!imem_req && !fetch_valid, "misaligned_quiet", {30'd0, imem_req, fetch_valid}, 32'd0);
        end
`endif
        if (fetch_valid && !stall && !redirect) begin
          consumed++;
          chk(exp_q.size() != 0, "unexpected_instr", pc_if, 32'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(pc_if == e.pc, "pc_if", pc_if, e.pc);
            chk(pc_plus_4_if == e.pc4, "pc_plus_4_if", pc_plus_4_if, e.pc4);
            chk(instr_if == e.instr, "instr_if", instr_if, e.instr);
          end
          if (directed) begin
            dir_consumed++;
            chk(cyc == next_dir_cyc, "zero_wait_timing", cyc, next_dir_cyc);
            next_dir_cyc += 2;
          end
        end
        hold_prev = fetch_valid && stall && !redirect;
        p_pc      = pc_if;
        p_pc4     = pc_plus_4_if;
        p_instr   = instr_if;
      end
    end
  end

  initial begin
    bit do_r;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(fetch_valid == 1'b0, "rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk(fetch_busy == 1'b1, "rst_busy", {31'd0, fetch_busy}, 32'd1);
    chk(pc_if == 32'd0, "rst_pc_if", pc_if, 32'd0);
    chk(pc_plus_4_if == 32'd0, "rst_pc4", pc_plus_4_if, 32'd0);
    chk(instr_if == NOP, "rst_instr", instr_if, NOP);
    chk(imem_addr == RST_PC, "rst_addr", imem_addr, RST_PC);

    // Zero-wait memory, no stalls: one instruction every 2 cycles starting at cycle 2
    gnt_pct   = 100;
    stall_pct = 0;
    lat_max   = 1;
    directed  = 1'b1;
    load_stream(RST_PC);
    imem_gnt  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    capture();
    repeat (20) step(1'b0, 32'd0);
    directed = 1'b0;

    // Wrap-around of PC+4 at the top of the address space
    step(1'b1, 32'hFFFF_FFF8);
    repeat (14) step(1'b0, 32'd0);
    chk(dir_consumed == 10, "zero_wait_count", dir_consumed, 10);
    chk(exp_q.size() <= 124, "wrap_progress", exp_q.size(), 124);

    // Stall held with a valid instruction, then released
    stall_pct = 100;
    repeat (6) step(1'b0, 32'd0);
    stall_pct = 0;
    repeat (4) step(1'b0, 32'd0);

    // Randomized memory latency, grants, stalls and redirects
    gnt_pct   = 65;
    stall_pct = 30;
    lat_max   = 4;
    for (int i = 0; i < 3000; i++) begin
      do_r = ($urandom_range(99) < 4) || ((cyc - last_redir) > 100);
      step(do_r, rand_target());
    end
    chk(consumed >= 100, "overall_progress", consumed, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and produces its `pc_if`, `pc_plus_4_if` and `instr_if` inputs.
- Owns the PC register and drives a single-outstanding req/gnt/rvalid instruction-memory port.
- Takes redirects (taken branch/jump) from EX and stalls from the hazard unit.
- Flags `fetch_busy` so the hazard unit inserts a bubble (IF/ID flush) when no instruction is ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on `instr_if` when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard-unit stall; same signal that holds IF/ID.
- redirect  in  1  EX redirect strobe.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- pc_if  out  32  PC of the held instruction.
- pc_plus_4_if  out  32  pc_if+4.
- instr_if  out  32  held instruction, or NOP_INSTR.
- fetch_valid  out  1  output register holds a real instruction.
- fetch_busy  out  1  equals !fetch_valid; drives the hazard unit's bubble request.

Behaviour:
- Reset (asynchronous, immediate):
  - PC register = RESET_PC; state = REQ.
  - pc_if = 0, pc_plus_4_if = 0, instr_if = NOP_INSTR, fetch_valid = 0.
- State enum:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
- At most one request outstanding. `imem_rvalid` is honoured only in WAIT/DROP; in REQ it is ignored, which covers stale responses after reset.
- Consume event = fetch_valid && !stall. IF/ID samples the outputs in that cycle.
- REQ:
  - imem_req = !fetch_valid || !stall (the output register is empty or emptying this cycle).
  - imem_gnt while imem_req -> WAIT.
- WAIT: imem_req = 0. On imem_rvalid:
  - Output register <= {pc, pc+4, imem_rdata}; fetch_valid <= 1.
  - PC <= PC+4; state -> REQ.
- Consume with no refill in the same cycle: output register <= {0, 0, NOP_INSTR}; fetch_valid <= 0.
- Stall with fetch_valid = 1: output register holds unchanged for any number of cycles.
- Redirect has highest priority (over stall, rvalid and consume):
  - PC <= redirect_pc.
  - Output register <= {0, 0, NOP_INSTR}; fetch_valid <= 0.
  - Next state by current state:
    - REQ without gnt -> REQ.
    - REQ with gnt in the same cycle (old address accepted) -> DROP.
    - WAIT without rvalid -> DROP.
    - WAIT with rvalid -> REQ; data discarded.
    - DROP without rvalid -> stays in DROP.
    - DROP with rvalid -> REQ.
- DROP without redirect: imem_req = 0; on imem_rvalid the data is discarded and state -> REQ. PC is not incremented.
- Latency:
  - First request issues in the first cycle after reset release.
  - Zero-wait memory (gnt in cycle N, rvalid in N+1): fetch_valid = 1 in N+2.
  - Sustained throughput: one instruction per 2 cycles.
  - Redirect penalty: the new target is requested no earlier than the next cycle (no combinational forwarding of redirect_pc).
- Arithmetic:
  - PC+4 and pc_plus_4_if are modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Without IF_MISALIGN_CHECK_EN, redirect_pc[1:0] is forced to 2'b00.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- With it defined:
  - Extra output port `fetch_misaligned` (out, 1).
  - A redirect with redirect_pc[1:0] != 0 sets `fetch_misaligned` (registered, sticky) and loads the PC unmodified.
  - While the flag is set, imem_req = 0 and fetch_valid stays 0.
  - The next redirect with an aligned target clears the flag and resumes fetch.
  - Reset clears the flag.
- Without it: no port; low bits are silently cleared.

Decomposition:
- Shared package `fetch_pkg`:
  - `fetch_state_e` enum (REQ/WAIT/DROP, 2 bits).
  - NOP_INSTR constant (32'h0000_0013), reused by the IF/ID flush path.
  - Default RESET_PC.
- No sub-module; a single module of one FSM plus a PC register and output register is natural.

Test Plan:
- Reset release with zero-wait memory returning 32'h00500093 at addr 0 -> imem_addr 0 then 4; pc_if = 0, pc_plus_4_if = 4, instr_if = 32'h00500093, fetch_valid = 1 two cycles after gnt.
- Stall held 5 cycles with fetch_valid = 1 -> outputs unchanged and imem_req = 0. Release -> outputs go to {0, 0, 32'h00000013} unless refilled.
- Redirect to 32'h0000_0100 while in WAIT, with rvalid (data 32'hDEADBEEF) 3 cycles later -> DEADBEEF never appears on instr_if; next imem_addr = 32'h100.
- Redirect with gnt in the same cycle -> DROP entered; the response is discarded; the following request uses the new PC.
- PC at 32'hFFFF_FFFC fetched -> pc_plus_4_if = 0; next imem_addr = 0.
- With IF_MISALIGN_CHECK_EN: redirect to 32'h102 -> fetch_misaligned = 1 and imem_req = 0. Then redirect to 32'h200 -> flag clears and imem_addr = 32'h200.
